// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder.
package systolic_pkg;

  localparam int DEFAULT_DWIDTH = 32;
  localparam int DEFAULT_N      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index of the last DRAIN cycle: the drain phase spans 2N-1 cycles.
  function automatic int drain_last_idx(input int n);
    return (2 * n) - 2;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Zero-reset shift register: D delay stages followed by one output register,
// so an input sampled at cycle c appears on dout at cycle c+1+D.
module skew_delay #(
  parameter int D      = 0,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] stage_r [0:D];

  // Shift the lane one stage per clock; reset flushes every stage to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k <= D; k++) begin
        stage_r[k] <= {DWIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int k = 1; k <= D; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign dout = stage_r[D];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array: accepts one
// column of A and one row of B per beat, skews them onto the west/north
// edges and sequences clear/accumulate/drain/done for the PE grid.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int N      = DEFAULT_N,
  parameter int KW     = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DWIDTH-1:0] in_a,
  input  logic [N*DWIDTH-1:0] in_b,
  output logic [N*DWIDTH-1:0] west_out,
  output logic [N*DWIDTH-1:0] north_out,
  output logic                pe_en,
  output logic                acc_clr_n,
  output logic                busy,
  output logic                done
);

  localparam int             DCW        = (2 * N > 2) ? $clog2(2 * N) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_last_idx(N));

  state_e              state_r;
  state_e              next_state_s;
  logic [KW-1:0]       k_len_r;
  logic [KW-1:0]       beat_cnt_r;
  logic [DCW-1:0]      drain_cnt_r;
  logic                accept_s;
  logic                last_beat_s;
  logic [N*DWIDTH-1:0] a_feed_s;
  logic [N*DWIDTH-1:0] b_feed_s;

  logic                in_ready_r;
  logic                pe_en_r;
  logic                acc_clr_n_r;
  logic                busy_r;
  logic                done_r;

  logic                in_ready_nxt_s;
  logic                pe_en_nxt_s;
  logic                acc_clr_n_nxt_s;
  logic                busy_nxt_s;
  logic                done_nxt_s;

  // in_ready_r is high exactly while the FSM sits in LOAD.
  assign accept_s    = in_valid && in_ready_r;
  assign last_beat_s = (beat_cnt_r == (k_len_r - KW'(1)));

  // Bubbles feed zeros so the a/b wavefronts stay aligned and add nothing.
  assign a_feed_s = accept_s ? in_a : {(N*DWIDTH){1'b0}};
  assign b_feed_s = accept_s ? in_b : {(N*DWIDTH){1'b0}};

  // Next-state logic of the sequencing FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_CLEAR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (k_len_r == {KW{1'b0}}) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept_s && last_beat_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Decode the control outputs for the state being entered, so they can be
  // registered and line up with the state register.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    pe_en_nxt_s     = 1'b0;
    acc_clr_n_nxt_s = 1'b1;
    busy_nxt_s      = 1'b1;
    done_nxt_s      = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_CLEAR: begin
        acc_clr_n_nxt_s = 1'b0;
      end
      ST_LOAD: begin
        in_ready_nxt_s = 1'b1;
        pe_en_nxt_s    = 1'b1;
      end
      ST_DRAIN: begin
        pe_en_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State register, latched inner dimension, beat and drain counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      k_len_r     <= {KW{1'b0}};
      beat_cnt_r  <= {KW{1'b0}};
      drain_cnt_r <= {DCW{1'b0}};
    end else begin
      state_r <= next_state_s;

      if ((state_r == ST_IDLE) && start) begin
        k_len_r <= k_len;
      end else begin
        k_len_r <= k_len_r;
      end

      if (state_r == ST_CLEAR) begin
        beat_cnt_r <= {KW{1'b0}};
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + KW'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end

      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + DCW'(1);
      end else begin
        drain_cnt_r <= {DCW{1'b0}};
      end
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_ready_r  <= 1'b0;
      pe_en_r     <= 1'b0;
      acc_clr_n_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      pe_en_r     <= pe_en_nxt_s;
      acc_clr_n_r <= acc_clr_n_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign pe_en     = pe_en_r;
  assign acc_clr_n = acc_clr_n_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Lane i is delayed by i extra cycles so row/column i meets the wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(
      .D      (i),
      .DWIDTH (DWIDTH)
    ) u_skew_a (
      .clk  (clk),
      .rstn (rstn),
      .din  (a_feed_s[i*DWIDTH +: DWIDTH]),
      .dout (west_out[i*DWIDTH +: DWIDTH])
    );

    skew_delay #(
      .D      (i),
      .DWIDTH (DWIDTH)
    ) u_skew_b (
      .clk  (clk),
      .rstn (rstn),
      .din  (b_feed_s[i*DWIDTH +: DWIDTH]),
      .dout (north_out[i*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a timeline reference model predicts
// every output each cycle, and a small PE-grid model checks the final products.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int KW   = 16;
  localparam int MAXC = 4096;
  localparam int BIG  = 1 << 30;

  logic            clk = 1'b0;
  logic            rstn, start, in_valid;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] in_a, in_b, west_out, north_out;
  logic            in_ready, pe_en, acc_clr_n, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: operation timeline in cycle numbers.
  bit              m_active = 1'b0;
  int              m_clear  = -10;
  int              m_done   = -10;
  int              m_klen   = 0;
  int              m_beats  = 0;
  int              floor_c  = 0;
  logic [N*DW-1:0] hist_a [MAXC];
  logic [N*DW-1:0] hist_b [MAXC];
  logic [31:0]     m_ref  [N][N];
  logic [31:0]     pe_acc [N][N];
  logic [31:0]     pe_a   [N][N];
  logic [31:0]     pe_b   [N][N];

  systolic_feeder #(.DWIDTH(DW), .N(N), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .west_out(west_out), .north_out(north_out), .pe_en(pe_en),
    .acc_clr_n(acc_clr_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_ready(input int t);
    return m_active && (t > m_clear) && (m_beats < m_klen);
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    logic [N*DW-1:0] ew, en;
    int idx;
    if (chk_en) begin
      ew = '0;
      en = '0;
      for (int i = 0; i < N; i++) begin
        idx = cyc - 1 - i;
        if (idx >= 0 && idx >= floor_c) begin
          ew[i*DW +: DW] = hist_a[idx][i*DW +: DW];
          en[i*DW +: DW] = hist_b[idx][i*DW +: DW];
        end
      end
      chk("west_out",  128'(west_out),  128'(ew));
      chk("north_out", 128'(north_out), 128'(en));
      chk("in_ready",  128'(in_ready),  128'(exp_ready(cyc)));
      chk("pe_en",     128'(pe_en),
          128'(m_active && cyc > m_clear && cyc < m_done));
      chk("acc_clr_n", 128'(acc_clr_n), 128'(!(m_active && cyc == m_clear)));
      chk("busy",      128'(busy),      128'(m_active));
      chk("done",      128'(done),      128'(m_active && cyc == m_done));
      if (m_active && cyc == m_done) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("pe_acc[%0d][%0d]", i, j), 128'(pe_acc[i][j]), 128'(m_ref[i][j]));
      end
    end
  endtask

  // Advance an output-stationary PE grid driven by the DUT's edge outputs.
  task automatic pe_step();
    logic [31:0] na [N][N];
    logic [31:0] nb [N][N];
    logic [31:0] ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain = west_out[i*DW +: DW];
        else        ain = pe_a[i][j-1];
        if (i == 0) bin = north_out[j*DW +: DW];
        else        bin = pe_b[i-1][j];
        if (!rstn || !acc_clr_n) pe_acc[i][j] = 32'd0;
        else if (pe_en)          pe_acc[i][j] = pe_acc[i][j] + ain * bin;
        na[i][j] = rstn ? ain : 32'd0;
        nb[i][j] = rstn ? bin : 32'd0;
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pe_a[i][j] = na[i][j];
        pe_b[i][j] = nb[i][j];
      end
  endtask

  // Apply this cycle's inputs to the reference timeline.
  task automatic model_update();
    if (!rstn) begin
      m_active = 1'b0;
      m_clear  = -10;
      m_done   = -10;
      floor_c  = cyc + 1;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_clear  = cyc + 1;
        m_klen   = int'(k_len);
        m_beats  = 0;
        m_done   = (k_len == '0) ? cyc + 2 : BIG;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) m_ref[i][j] = 32'd0;
      end
    end else begin
      if (exp_ready(cyc) && in_valid) begin
        hist_a[cyc] = in_a;
        hist_b[cyc] = in_b;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            m_ref[i][j] = m_ref[i][j] + in_a[i*DW +: DW] * in_b[j*DW +: DW];
        m_beats++;
        if (m_beats == m_klen) m_done = cyc + 2 * N;
      end
      if (cyc == m_done) m_active = 1'b0;
    end
  endtask

  task automatic tick();
    check_cycle();
    pe_step();
    model_update();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_beat(input bit v);
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      in_a[i*DW +: DW] = $urandom;
      in_b[i*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      hist_a[c] = '0;
      hist_b[c] = '0;
    end
    rstn = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rstn = 1'b1;
    tick();

    // k_len=1, fixed operands: single wavefront then done at L+8.
    start = 1'b1; k_len = 16'd1; tick();
    start = 1'b0; tick();
    in_valid = 1'b1;
    in_a = {32'd4, 32'd3, 32'd2, 32'd1};
    in_b = {32'd8, 32'd7, 32'd6, 32'd5};
    tick();
    in_valid = 1'b0; in_a = '0; in_b = '0;
    for (int n = 0; n < 10; n++) tick();

    // k_len=3 with a two-cycle stall between beats.
    start = 1'b1; k_len = 16'd3; tick();
    start = 1'b0; tick();
    rand_beat(1'b1); tick();
    rand_beat(1'b0); tick();
    rand_beat(1'b0); tick();
    rand_beat(1'b1); tick();
    rand_beat(1'b1); tick();
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    // k_len=0: clear, done, in_ready never raised even with in_valid held.
    start = 1'b1; k_len = 16'd0; in_valid = 1'b1; tick();
    start = 1'b0; for (int n = 0; n < 4; n++) tick();
    in_valid = 1'b0; tick();

    // Start pulses during LOAD and DRAIN are ignored.
    start = 1'b1; k_len = 16'd4; tick();
    start = 1'b0; tick();
    for (int n = 0; n < 16; n++) begin
      rand_beat(n != 2);
      start = (n == 1) || (n == 8);
      k_len = (n == 1) ? 16'd9 : 16'd2;
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 4; n++) tick();

    // Reset mid-LOAD after 2 of 4 beats, then a fresh operation.
    start = 1'b1; k_len = 16'd4; tick();
    start = 1'b0; tick();
    rand_beat(1'b1); tick();
    rand_beat(1'b1); tick();
    rstn = 1'b0; rand_beat(1'b1); tick();
    rstn = 1'b1; in_valid = 1'b0;
    for (int n = 0; n < 12; n++) tick();
    start = 1'b1; k_len = 16'd4; tick();
    start = 1'b0; tick();
    for (int n = 0; n < 4; n++) begin rand_beat(1'b1); tick(); end
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    // Random traffic: random k_len, valid gaps, stray starts, rare resets.
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 7) == 0);
      k_len = KW'($urandom_range(0, 6));
      rand_beat($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 249) != 0);
      tick();
    end
    rstn = 1'b1; start = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 12; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning operand width of one matrix element.
REQ-002 SHALL have parameter N, default 4, meaning array dimension (N rows x N columns of PEs).
REQ-003 SHALL have parameter KW, default 16, meaning width of the inner-dimension length k_len.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  meaning synchronous active-low reset.
REQ-006 SHALL have port start  input  1  meaning a one-cycle request to begin a matrix product.
REQ-007 SHALL have port k_len  input  KW  meaning inner dimension K, sampled when start is accepted.
REQ-008 SHALL have port in_valid  input  1  meaning in_a/in_b hold one beat (column k of A, row k of B).
REQ-009 SHALL have port in_ready  output  1  meaning the feeder accepts a beat this cycle.
REQ-010 SHALL have port in_a  input  N*DWIDTH  meaning element i of the beat is A[i][k], row i.
REQ-011 SHALL have port in_b  input  N*DWIDTH  meaning element j of the beat is B[k][j], column j.
REQ-012 SHALL have port west_out  output  N*DWIDTH  meaning element i drives the west_in of PE(i,0).
REQ-013 SHALL have port north_out  output  N*DWIDTH  meaning element j drives the north_in of PE(0,j).
REQ-014 SHALL have port pe_en  output  1  meaning accumulate enable broadcast to all PEs.
REQ-015 SHALL have port acc_clr_n  output  1  meaning active-low, one-cycle accumulator clear, combined into the PE reset.
REQ-016 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-017 SHALL have port done  output  1  meaning a one-cycle pulse when every PE holds its final sum.

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR, LOAD, DRAIN and DONE.
REQ-019 SHALL transition from IDLE to CLEAR on start; start in any other state SHALL be ignored.
REQ-020 SHALL drive acc_clr_n=0 only in CLEAR, which lasts exactly one cycle, and then go to LOAD; if the latched k_len=0 it SHALL go to DONE instead.
REQ-021 SHALL drive in_ready=1 only in LOAD; a beat is accepted when in_valid && in_ready, and the beat counter SHALL increment by one.
REQ-022 SHALL go to DRAIN after the k_len-th accepted beat (cycle L) and stay in DRAIN exactly 2N-1 cycles (L+1 .. L+2N-1).
REQ-023 SHALL hold DONE one cycle (done=1 at L+2N) and then return to IDLE.
REQ-024 SHALL drive pe_en=1 in LOAD and DRAIN and 0 in all other states.
REQ-025 SHALL register the skew so that beat element i accepted at cycle c appears on west_out[i] and north_out[i] at cycle c+1+i (row/column 0 has a latency of 1).
REQ-026 SHALL shift zero into every skew line in any cycle without an accepted beat (stall, DRAIN, IDLE), so the a/b alignment is preserved and bubbles add zero products.
REQ-027 SHALL pass operands unmodified with no arithmetic; widths are exactly DWIDTH per lane.
REQ-028 SHALL allow a stall of any length in LOAD without changing the results; the DRAIN start always follows the last accepted beat.

Reset
REQ-029 SHALL, with rstn=0 on a clock edge, enter IDLE, clear the beat counter, and zero every skew register.
REQ-030 SHALL, on reset, drive in_ready=0, pe_en=0, acc_clr_n=1, busy=0, done=0, west_out=0 and north_out=0.
REQ-031 SHALL treat a reset mid-operation (any state) identically to a reset from IDLE, producing no done pulse.

Structure
REQ-032 SHALL place the FSM state enum and the default DWIDTH/N constants in a shared package systolic_pkg.
REQ-033 SHALL instantiate sub-module skew_delay (parameterised depth D, width DWIDTH, zero-reset shift register) once per lane, with D=i for lane i (lane 0 is a single output register).

Verification
REQ-034 SHALL verify N=4, k_len=1, a=(1,2,3,4), b=(5,6,7,8) accepted at L -> west_out[i]=a[i] and north_out[i]=b[i] only at L+1+i, zero elsewhere, and done at L+8.
REQ-035 SHALL verify k_len=3 with in_valid low for 2 cycles between beats 1 and 2 -> a 4x4 PE-model product equals the reference A*B, and done at last-beat+8.
REQ-036 SHALL verify start with k_len=0 -> CLEAR one cycle (acc_clr_n=0), done the next cycle, and in_ready never asserted.
REQ-037 SHALL verify start pulsed during LOAD and DRAIN -> no effect on the counter, the state or the done timing.
REQ-038 SHALL verify rstn=0 for 1 cycle mid-LOAD after 2 of 4 beats -> all outputs at reset values the next cycle, no done, and a fresh start works normally.
